// File: rtl/sm_input_reader.sv
// Switch/key input peripheral: synchronises and debounces SW[9:0] and KEY[1:0], and
// exposes level, sticky rise, mask and key-press count as a 4-word register window.
module sm_input_reader #(
    parameter logic [31:0]           BASE_ADDR    = 32'h0000_7F20,
    parameter int unsigned           DEBOUNCE_W   = 16,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_MAX = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sw_async,
    input  logic [1:0]  key_async,
    input  logic [31:0] busAddr,
    input  logic        busWriteEnable,
    input  logic [31:0] busWriteData,
    output logic        busHit,
    output logic [31:0] busReadData,
    output logic        irq
);

    localparam int NBITS = 12;
    localparam logic [DEBOUNCE_W-1:0] CNT_LAST = DEBOUNCE_MAX - 1'b1;

    logic [9:0]       sw_meta_q, sw_sync_q;
    logic [1:0]       key_meta_q, key_sync_q;
    logic [NBITS-1:0] in_w;
    logic [NBITS-1:0] stable_q, stable_d;
    logic [NBITS-1:0] rise_w;
    logic [NBITS-1:0] edge_q, edge_d;
    logic [NBITS-1:0] mask_q, mask_d;
    logic [15:0]      press_cnt_q, press_cnt_d;
    logic             irq_q;
    logic             wr_w;
    logic [1:0]       sel_w;
    logic             unused_w;

    // Keys idle high, so their sync flops reset to "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
        end else begin
            sw_meta_q  <= sw_async;
            sw_sync_q  <= sw_meta_q;
            key_meta_q <= key_async;
            key_sync_q <= key_meta_q;
        end
    end

    assign in_w = {~key_sync_q, sw_sync_q};

    generate
        for (genvar gi = 0; gi < NBITS; gi++) begin : g_db
            logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
            logic                  bit_q, bit_d;

            always_comb begin
                cnt_d = cnt_q;
                bit_d = bit_q;
                if (in_w[gi] == bit_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    bit_d = in_w[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    bit_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    bit_q <= bit_d;
                end
            end

            assign stable_q[gi] = bit_q;
            assign stable_d[gi] = bit_d;
        end
    endgenerate

    assign rise_w = stable_d & ~stable_q;

    assign busHit = (busAddr[31:4] == BASE_ADDR[31:4]);
    assign wr_w   = busWriteEnable & busHit;
    assign sel_w  = busAddr[3:2];

    always_comb begin
        edge_d      = edge_q;
        mask_d      = mask_q;
        press_cnt_d = press_cnt_q;
        if (wr_w && sel_w == 2'd1) edge_d = edge_q & ~busWriteData[NBITS-1:0];
        if (wr_w && sel_w == 2'd2) mask_d = busWriteData[NBITS-1:0];
        if (wr_w && sel_w == 2'd3) press_cnt_d = '0;
        // Applied after the clear so a same-cycle event always survives.
        edge_d      = edge_d | rise_w;
        press_cnt_d = press_cnt_d + {15'b0, rise_w[10]} + {15'b0, rise_w[11]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_q      <= '0;
            mask_q      <= '0;
            press_cnt_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            edge_q      <= edge_d;
            mask_q      <= mask_d;
            press_cnt_q <= press_cnt_d;
            irq_q       <= |(edge_q & mask_q);
        end
    end

    always_comb begin
        busReadData = '0;
        if (busHit) begin
            case (sel_w)
                2'd0:    busReadData = {20'b0, stable_q};
                2'd1:    busReadData = {20'b0, edge_q};
                2'd2:    busReadData = {20'b0, mask_q};
                default: busReadData = {16'b0, press_cnt_q};
            endcase
        end
    end

    assign irq = irq_q;

    assign unused_w = ^{busAddr[1:0], busWriteData[31:NBITS]};

endmodule
